// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length,
// common mouse commands and default timing at a 65 MHz pixel clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FIN
  } ps2_tx_state_e;

  // start + 8 data + parity + stop; the 11th falling edge is the ACK edge
  localparam int PS2_FRAME_LEN = 11;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  localparam int PS2_INHIBIT_CYCLES = 6500;    // 100 us
  localparam int PS2_TIMEOUT_CYCLES = 975000;  // 15 ms

  // {stop, odd parity, data}; bit 0 goes out first
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin, with a falling-edge pulse.
module ps2_line_sync (
  input  logic pclk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic s0, s1, lvl_q;

  // Flops reset high (bus idle level) so leaving reset never fakes an edge.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      s0    <= 1'b1;
      s1    <= 1'b1;
      lvl_q <= 1'b1;
    end else begin
      s0    <= pin;
      s1    <= s0;
      lvl_q <= s1;
    end
  end

  assign level = s1;
  assign fall  = lvl_q & ~s1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Inhibits the clock, issues the
// request-to-send, shifts out data/parity/stop on device clock falls and
// reports the device ACK. Owns the open-drain lines while busy is high.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_LEN - 1);

  logic clk_sync, clk_fall, data_sync, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .pclk (pclk),
    .reset(reset),
    .pin  (ps2_clk_in),
    .level(clk_sync),
    .fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .pclk (pclk),
    .reset(reset),
    .pin  (ps2_data_in),
    .level(data_sync),
    .fall (data_fall_unused)
  );

  ps2_tx_state_e    state, nxt_state;
  logic [INH_W-1:0] inh_cnt, nxt_inh;
  logic [TO_W-1:0]  to_cnt, nxt_to;
  logic [9:0]       shreg, nxt_shreg;
  logic [3:0]       bit_cnt, nxt_bit;
  logic             ack_ok_r, nxt_ack_r;
  logic             nxt_clk_oe, nxt_data_oe, nxt_busy, nxt_done, nxt_ack_ok, nxt_err;

  // State, counters and registered outputs; async reset drops both lines at once.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      ack_ok_r    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= nxt_state;
      inh_cnt     <= nxt_inh;
      to_cnt      <= nxt_to;
      shreg       <= nxt_shreg;
      bit_cnt     <= nxt_bit;
      ack_ok_r    <= nxt_ack_r;
      ps2_clk_oe  <= nxt_clk_oe;
      ps2_data_oe <= nxt_data_oe;
      busy        <= nxt_busy;
      done        <= nxt_done;
      ack_ok      <= nxt_ack_ok;
      err         <= nxt_err;
    end
  end

  // Next-state and next-output logic; timeout overrides everything else.
  always_comb begin
    nxt_state   = state;
    nxt_inh     = inh_cnt;
    nxt_to      = to_cnt;
    nxt_shreg   = shreg;
    nxt_bit     = bit_cnt;
    nxt_ack_r   = ack_ok_r;
    nxt_clk_oe  = ps2_clk_oe;
    nxt_data_oe = ps2_data_oe;
    nxt_busy    = busy;
    nxt_done    = 1'b0;
    nxt_ack_ok  = 1'b0;
    nxt_err     = 1'b0;

    case (state)
      ST_IDLE: begin
        nxt_clk_oe  = 1'b0;
        nxt_data_oe = 1'b0;
        nxt_busy    = 1'b0;
        // busy is still high on the cycle a timeout reports done
        if (tx_start && !busy) begin
          nxt_state  = ST_INHIBIT;
          nxt_busy   = 1'b1;
          nxt_clk_oe = 1'b1;
          nxt_shreg  = ps2_frame(tx_data);
          nxt_bit    = '0;
          nxt_inh    = '0;
          nxt_ack_r  = 1'b0;
        end
      end
      ST_INHIBIT: begin
        nxt_inh = inh_cnt + 1'b1;
        if (inh_cnt == INH_LAST) begin
          nxt_state   = ST_REQ;
          nxt_clk_oe  = 1'b0;
          nxt_data_oe = 1'b1;  // start bit
          nxt_to      = '0;
        end
      end
      ST_REQ: begin
        nxt_to = to_cnt + 1'b1;
        if (clk_fall) begin
          nxt_state   = ST_SEND;
          nxt_data_oe = ~shreg[0];
          nxt_bit     = 4'd1;
        end
      end
      ST_SEND: begin
        nxt_to = to_cnt + 1'b1;
        if (clk_fall) begin
          if (bit_cnt == LAST_BIT) begin
            nxt_ack_r = ~data_sync;
            nxt_state = ST_ACK;
          end else begin
            nxt_shreg   = {1'b0, shreg[9:1]};
            nxt_data_oe = ~shreg[1];
            nxt_bit     = bit_cnt + 1'b1;
          end
        end
      end
      ST_ACK: begin
        nxt_to    = to_cnt + 1'b1;
        nxt_state = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        nxt_to = to_cnt + 1'b1;
        if (clk_sync && data_sync) begin
          nxt_state  = ST_FIN;
          nxt_done   = 1'b1;
          nxt_ack_ok = ack_ok_r;
        end
      end
      ST_FIN: begin
        nxt_state = ST_IDLE;
        nxt_busy  = 1'b0;
      end
      default: nxt_state = ST_IDLE;
    endcase

    if ((state inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE}) && to_cnt == TO_LAST) begin
      nxt_state   = ST_IDLE;
      nxt_clk_oe  = 1'b0;
      nxt_data_oe = 1'b0;
      nxt_busy    = 1'b1;
      nxt_done    = 1'b1;
      nxt_err     = 1'b1;
      nxt_ack_ok  = 1'b0;
    end
  end

endmodule
